// File: rtl/pdm_capture_pkg.sv
// Shared definitions for the multi-channel PDM capture engine:
// command encodings, FSM state type and width helpers.
package pdm_capture_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Bus read data width and byte-to-word address shift
  localparam int RD_W       = 32;
  localparam int WORD_SHIFT = 2;

  // Bit width needed to hold values 0..value-1, never less than one bit
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/pdm_word_buf.sv
// Per-channel word buffer: CHANNELS x DEPTH words of WORD_W bits.
// One write port stores all channels at the same word index, one
// registered read port addressed by {channel, word}.
module pdm_word_buf
  import pdm_capture_pkg::*;
#(
  parameter  int CHANNELS = 2,
  parameter  int WORD_W   = 32,
  parameter  int DEPTH    = 1024,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = clog2_min1(CHANNELS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [AW-1:0]                    wr_idx,
  input  logic [CHANNELS-1:0][WORD_W-1:0]  wr_data,
  input  logic [CW-1:0]                    rd_ch,
  input  logic [AW-1:0]                    rd_word,
  output logic [WORD_W-1:0]                rd_data
);

  // Sized to the full channel-select code space so every {ch, word} address is in range
  logic [WORD_W-1:0] mem [(2**CW)*DEPTH];

  // Parallel write of every channel's completed word at the shared index
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mem[{CW'(c), wr_idx}] <= wr_data[c];
      end
    end
  end

  // Registered read; a same-cycle write is not visible until the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (int'(rd_ch) < CHANNELS) begin
      rd_data <= mem[{rd_ch, rd_word}];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/pdm_capture_mc.sv
// Multi-channel PDM capture engine. Deserialises CHANNELS one-bit PDM
// streams into WORD_W-bit words stored in a per-channel buffer that the
// bus reads back by byte address.
// Optional feature macro: PDM_CAPTURE_RING_EN enables continuous wrap
// capture through the ring input and the wrapped flag.
module pdm_capture_mc
  import pdm_capture_pkg::*;
#(
  parameter  int CHANNELS = 2,
  parameter  int WORD_W   = 32,
  parameter  int DEPTH    = 1024,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          ctrl,
  input  logic                ring,
  input  logic                pdm_tick,
  input  logic [CHANNELS-1:0] pdm_data,
  input  logic [RD_W-1:0]     rd_addr,
  output logic [RD_W-1:0]     rd_data,
  output logic                bsy,
  output logic                done,
  output logic [AW:0]         wr_count,
  output logic                wrapped
);

  localparam int          CW     = clog2_min1(CHANNELS);
  localparam int          BW     = clog2_min1(WORD_W);
  localparam logic [AW:0] WC_MAX = (AW+1)'(DEPTH);

  state_t state;
  state_t state_next;

  logic [CHANNELS-1:0][WORD_W-1:0] sr;
  logic [CHANNELS-1:0][WORD_W-1:0] sr_next;
  logic [BW-1:0]                   bit_cnt;
  logic [AW-1:0]                   wr_idx;

  logic              cmd_start;
  logic              cmd_stop;
  logic              cmd_clear;
  logic              tick_cap;
  logic              word_done;
  logic              last_idx;
  logic              ring_on;
  logic [CW-1:0]     rd_ch;
  logic [WORD_W-1:0] buf_rd;
  logic              unused_bits;

  assign cmd_start = (ctrl == CMD_START);
  assign cmd_stop  = (ctrl == CMD_STOP);
  assign cmd_clear = (ctrl == CMD_CLEAR);

  // Clear beats a coinciding tick, so such a tick never shifts or writes
  assign tick_cap  = (state == ST_CAPTURE) && pdm_tick && !cmd_clear;
  assign word_done = tick_cap && (bit_cnt == BW'(WORD_W - 1));
  assign last_idx  = (wr_idx == AW'(DEPTH - 1));

  // Only the address bits that select word and channel are decoded
  assign unused_bits = ^{rd_addr, ring};

`ifdef PDM_CAPTURE_RING_EN
  assign ring_on = ring;

  // Sticky flag recording that a ring capture has wrapped to index 0
  always_ff @(posedge clk) begin
    if (rst || cmd_clear) begin
      wrapped <= 1'b0;
    end else if (cmd_start && state != ST_CAPTURE) begin
      wrapped <= 1'b0;
    end else if (word_done && last_idx && ring) begin
      wrapped <= 1'b1;
    end
  end
`else
  assign ring_on = 1'b0;
  assign wrapped = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: clear overrides everything, the final word of a single-shot ends capture
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_start) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cmd_clear)                           state_next = ST_IDLE;
        else if (word_done && last_idx && !ring_on) state_next = ST_DONE;
        else if (cmd_stop)                       state_next = ST_DONE;
      end
      ST_DONE: begin
        if (cmd_clear)      state_next = ST_IDLE;
        else if (cmd_start) state_next = ST_CAPTURE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    bsy  = (state == ST_CAPTURE);
    done = (state == ST_DONE);
  end

  // Each channel shifts in at the LSB so the first sampled bit ends in the MSB
  always_comb begin
    sr_next = sr;
    for (int c = 0; c < CHANNELS; c++) begin
      sr_next[c] = {sr[c][WORD_W-2:0], pdm_data[c]};
    end
  end

  // Capture datapath: shift registers, bit counter, write index and word count
  always_ff @(posedge clk) begin
    if (rst || cmd_clear) begin
      sr       <= '0;
      bit_cnt  <= '0;
      wr_idx   <= '0;
      wr_count <= '0;
    end else if (cmd_start && state != ST_CAPTURE) begin
      sr       <= '0;
      bit_cnt  <= '0;
      wr_idx   <= '0;
      wr_count <= '0;
    end else if (tick_cap) begin
      sr <= sr_next;
      if (word_done) begin
        bit_cnt <= '0;
        wr_idx  <= wr_idx + AW'(1);
        if (wr_count != WC_MAX) begin
          wr_count <= wr_count + (AW+1)'(1);
        end
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  // Channel select sits just above the word index; a single channel has no select bits
  always_comb begin
    rd_ch = '0;
    if (CHANNELS > 1) begin
      rd_ch = rd_addr[WORD_SHIFT + AW +: CW];
    end
  end

  pdm_word_buf #(
    .CHANNELS (CHANNELS),
    .WORD_W   (WORD_W),
    .DEPTH    (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (word_done),
    .wr_idx  (wr_idx),
    .wr_data (sr_next),
    .rd_ch   (rd_ch),
    .rd_word (rd_addr[WORD_SHIFT +: AW]),
    .rd_data (buf_rd)
  );

  assign rd_data = RD_W'(buf_rd);

endmodule

// File: tb/tb_pdm_capture_mc.sv
// Self-checking bench for pdm_capture_mc (CHANNELS=2, WORD_W=8, DEPTH=4)
// against a behavioural capture model with randomized stimulus.
// Honours PDM_CAPTURE_RING_EN the same way the design does.
module tb_pdm_capture_mc;

  localparam int CH = 2;
  localparam int WW = 8;
  localparam int DP = 4;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_START = 2'b01;
  localparam logic [1:0] C_STOP  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

`ifdef PDM_CAPTURE_RING_EN
  localparam bit RING_BUILT = 1'b1;
`else
  localparam bit RING_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    ctrl;
  logic          ring;
  logic          pdm_tick;
  logic [CH-1:0] pdm_data;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_data;
  logic          bsy;
  logic          done;
  logic [2:0]    wr_count;
  logic          wrapped;

  int vectors = 0;
  int errors  = 0;

  // Reference model: capture phase 0 idle, 1 capturing, 2 finished
  int          m_phase;
  int          m_bits;
  int          m_idx;
  int          m_count;
  bit          m_wrapped;
  int unsigned m_acc [CH];
  int unsigned m_mem [CH][DP];
  bit          m_known [CH][DP];
  int unsigned m_rd;
  bit          m_rd_known;

  pdm_capture_mc #(.CHANNELS(CH), .WORD_W(WW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (ctrl),
    .ring     (ring),
    .pdm_tick (pdm_tick),
    .pdm_data (pdm_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .bsy      (bsy),
    .done     (done),
    .wr_count (wr_count),
    .wrapped  (wrapped)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_status();
    return {m_phase == 1, m_phase == 2, 3'(m_count), m_wrapped};
  endfunction

  task automatic model_reset_counts();
    m_bits = 0; m_idx = 0; m_count = 0; m_wrapped = 1'b0;
    for (int c = 0; c < CH; c++) m_acc[c] = 0;
  endtask

  // Apply one clock edge of behaviour to the model using the inputs held at that edge
  task automatic model_update();
    int ch;
    int wd;
    ch = (rd_addr >> 4) & 1;
    wd = (rd_addr >> 2) & 3;
    if (rst) begin
      m_rd = 0; m_rd_known = 1'b1;
    end else begin
      m_rd = m_mem[ch][wd]; m_rd_known = m_known[ch][wd];
    end
    if (rst || ctrl == C_CLEAR) begin
      m_phase = 0;
      model_reset_counts();
    end else if (m_phase == 1) begin
      if (pdm_tick) begin
        for (int c = 0; c < CH; c++) m_acc[c] = ((m_acc[c] << 1) | pdm_data[c]) & 32'hFF;
        m_bits++;
        if (m_bits == WW) begin
          for (int c = 0; c < CH; c++) begin
            m_mem[c][m_idx] = m_acc[c];
            m_known[c][m_idx] = 1'b1;
          end
          m_bits = 0;
          if (m_count < DP) m_count++;
          if (m_idx == DP - 1) begin
            m_idx = 0;
            if (RING_BUILT && ring) m_wrapped = 1'b1;
            else m_phase = 2;
          end else begin
            m_idx++;
          end
        end
      end
      if (ctrl == C_STOP) m_phase = 2;
    end else if (ctrl == C_START) begin
      m_phase = 1;
      model_reset_counts();
    end
  endtask

  task automatic step(input logic [1:0] c, input logic t, input logic [CH-1:0] d);
    ctrl = c; pdm_tick = t; pdm_data = d;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_addr = 32'h0;
    step(C_NONE, 1'b0, 2'b00);
    step(C_NONE, 1'b1, 2'b11);
    vectors++;
    if ({bsy, done, wr_count, wrapped} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_status got %b exp %b", {bsy, done, wr_count, wrapped}, 6'b0);
    end
    vectors++;
    if (rd_data !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_rd_data got %h exp %h", rd_data, 32'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_capture();
    ring = 1'b0; rd_addr = 32'h0;
    step(C_START, 1'b0, 2'b00);
    for (int i = 0; i < 32; i++) begin
      step(C_NONE, 1'b1, {~i[0], 1'b1});
      vectors++;
      if ({bsy, done, wr_count, wrapped} !== exp_status()) begin
        errors++; $display("[TB] FAIL full_status tick %0d got %b exp %b", i, {bsy, done, wr_count, wrapped}, exp_status());
      end
    end
    vectors++;
    if ({bsy, done, wr_count, wrapped} !== {1'b0, 1'b1, 3'd4, 1'b0}) begin
      errors++; $display("[TB] FAIL full_done got %b exp %b", {bsy, done, wr_count, wrapped}, {1'b0, 1'b1, 3'd4, 1'b0});
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 32'(a * 4);
      step(C_NONE, 1'b0, 2'b00);
      vectors++;
      if (rd_data !== ((a < 4) ? 32'hFF : 32'hAA) || rd_data !== m_rd) begin
        errors++; $display("[TB] FAIL full_read addr %h got %h exp %h", rd_addr, rd_data, (a < 4) ? 32'hFF : 32'hAA);
      end
    end
  endtask

  task automatic test_stop();
    step(C_START, 1'b0, 2'b00);
    for (int i = 0; i < 12; i++) step(C_NONE, 1'b1, 2'($urandom));
    step(C_STOP, 1'b0, 2'b00);
    vectors++;
    if ({bsy, done, wr_count, wrapped} !== {1'b0, 1'b1, 3'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL stop_status got %b exp %b", {bsy, done, wr_count, wrapped}, {1'b0, 1'b1, 3'd1, 1'b0});
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 32'(a * 4);
      step(C_NONE, 1'b0, 2'b00);
      vectors++;
      if (rd_data !== m_rd) begin
        errors++; $display("[TB] FAIL stop_read addr %h got %h exp %h", rd_addr, rd_data, m_rd);
      end
    end
    rd_addr = 32'h14;
    step(C_NONE, 1'b0, 2'b00);
    vectors++;
    if (rd_data !== 32'hAA) begin
      errors++; $display("[TB] FAIL stop_word1_kept got %h exp %h", rd_data, 32'hAA);
    end
  endtask

  task automatic test_stop_on_word();
    step(C_START, 1'b0, 2'b00);
    for (int i = 0; i < 7; i++) step(C_NONE, 1'b1, 2'($urandom));
    step(C_STOP, 1'b1, 2'($urandom));
    vectors++;
    if ({bsy, done, wr_count, wrapped} !== {1'b0, 1'b1, 3'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL stopword_status got %b exp %b", {bsy, done, wr_count, wrapped}, {1'b0, 1'b1, 3'd1, 1'b0});
    end
    for (int a = 0; a < 8; a += 4) begin
      rd_addr = 32'(a * 4);
      step(C_NONE, 1'b0, 2'b00);
      vectors++;
      if (rd_data !== m_rd) begin
        errors++; $display("[TB] FAIL stopword_read addr %h got %h exp %h", rd_addr, rd_data, m_rd);
      end
    end
  endtask

  task automatic test_ring();
    logic [5:0] final_exp;
    final_exp = RING_BUILT ? {1'b1, 1'b0, 3'd4, 1'b1} : {1'b0, 1'b1, 3'd4, 1'b0};
    ring = 1'b1;
    step(C_START, 1'b0, 2'b00);
    for (int i = 0; i < 40; i++) begin
      step(C_NONE, 1'b1, 2'($urandom));
      vectors++;
      if ({bsy, done, wr_count, wrapped} !== exp_status()) begin
        errors++; $display("[TB] FAIL ring_status tick %0d got %b exp %b", i, {bsy, done, wr_count, wrapped}, exp_status());
      end
    end
    vectors++;
    if ({bsy, done, wr_count, wrapped} !== final_exp) begin
      errors++; $display("[TB] FAIL ring_final got %b exp %b", {bsy, done, wr_count, wrapped}, final_exp);
    end
    for (int a = 0; a < 8; a += 4) begin
      rd_addr = 32'(a * 4);
      step(C_NONE, 1'b0, 2'b00);
      vectors++;
      if (rd_data !== m_rd) begin
        errors++; $display("[TB] FAIL ring_read addr %h got %h exp %h", rd_addr, rd_data, m_rd);
      end
    end
    step(C_STOP, 1'b0, 2'b00);
    ring = 1'b0;
  endtask

  task automatic test_clear();
    step(C_START, 1'b0, 2'b00);
    for (int i = 0; i < 10; i++) step(C_NONE, 1'b1, 2'($urandom));
    step(C_CLEAR, 1'b1, 2'($urandom));
    vectors++;
    if ({bsy, done, wr_count, wrapped} !== 6'b0) begin
      errors++; $display("[TB] FAIL clear_status got %b exp %b", {bsy, done, wr_count, wrapped}, 6'b0);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 32'(a * 4);
      step(C_NONE, 1'b0, 2'b00);
      vectors++;
      if (rd_data !== m_rd) begin
        errors++; $display("[TB] FAIL clear_read addr %h got %h exp %h", rd_addr, rd_data, m_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(C_START, 1'b0, 2'b00);
    for (int i = 0; i < 13; i++) step(C_NONE, 1'b1, 2'($urandom));
    rst = 1'b1;
    step(C_NONE, 1'b1, 2'($urandom));
    rst = 1'b0;
    vectors++;
    if ({bsy, done, wr_count, wrapped} !== 6'b0) begin
      errors++; $display("[TB] FAIL rstmid_status got %b exp %b", {bsy, done, wr_count, wrapped}, 6'b0);
    end
    rd_addr = 32'h04;
    step(C_NONE, 1'b0, 2'b00);
    vectors++;
    if (rd_data !== m_rd) begin
      errors++; $display("[TB] FAIL rstmid_read got %h exp %h", rd_data, m_rd);
    end
    step(C_START, 1'b0, 2'b00);
    vectors++;
    if ({bsy, done, wr_count, wrapped} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL rstmid_restart got %b exp %b", {bsy, done, wr_count, wrapped}, {1'b1, 1'b0, 3'd0, 1'b0});
    end
    step(C_CLEAR, 1'b0, 2'b00);
  endtask

  task automatic test_back_to_back();
    rd_addr = 32'h10;
    step(C_START, 1'b0, 2'b00);
    for (int i = 0; i < 7; i++) step(i == 3 ? C_START : C_NONE, 1'b1, 2'($urandom));
    step(C_NONE, 1'b1, 2'($urandom));
    vectors++;
    if (rd_data !== m_rd) begin
      errors++; $display("[TB] FAIL b2b_old_data got %h exp %h", rd_data, m_rd);
    end
    step(C_NONE, 1'b1, 2'($urandom));
    vectors++;
    if (rd_data !== m_rd || wr_count !== 3'd1) begin
      errors++; $display("[TB] FAIL b2b_new_data got %h/%0d exp %h/1", rd_data, wr_count, m_rd);
    end
    for (int i = 0; i < 30; i++) begin
      step(C_NONE, 1'b1, 2'($urandom));
      vectors++;
      if ({bsy, done, wr_count, wrapped} !== exp_status()) begin
        errors++; $display("[TB] FAIL b2b_status tick %0d got %b exp %b", i, {bsy, done, wr_count, wrapped}, exp_status());
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] c;
    for (int round = 0; round < 3; round++) begin
      ring = 1'($urandom);
      step(C_START, 1'b0, 2'b00);
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 99);
        c = (r < 4) ? C_START : (r == 4) ? C_STOP : (r == 5) ? C_CLEAR : C_NONE;
        rd_addr = ($urandom & 32'hFFFF_FFE0) | ($urandom & 32'h1C);
        step(c, $urandom_range(0, 2) != 0, 2'($urandom));
        vectors++;
        if ({bsy, done, wr_count, wrapped} !== exp_status()) begin
          errors++; $display("[TB] FAIL rand_status r%0d c%0d got %b exp %b", round, i, {bsy, done, wr_count, wrapped}, exp_status());
        end
        if (m_rd_known) begin
          vectors++;
          if (rd_data !== m_rd) begin
            errors++; $display("[TB] FAIL rand_read addr %h got %h exp %h", rd_addr, rd_data, m_rd);
          end
        end
      end
    end
    ring = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctrl = C_NONE; ring = 1'b0; pdm_tick = 1'b0; pdm_data = '0; rd_addr = '0;
    m_phase = 0;
    model_reset_counts();
    for (int c = 0; c < CH; c++)
      for (int w = 0; w < DP; w++) begin
        m_mem[c][w] = 0; m_known[c][w] = 1'b0;
      end
    test_reset();
    test_full_capture();
    test_stop();
    test_stop_on_word();
    test_ring();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
